// File: rtl/maze_pkg.sv
// Shared types for the maze path reader: packed locations, move codes and replay states.
package maze_pkg;

    typedef logic [7:0] loc_t;

    typedef enum logic [1:0] {
        DIR_YDEC = 2'b00,
        DIR_XINC = 2'b01,
        DIR_XDEC = 2'b10,
        DIR_YINC = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } rd_state_t;

    // Longest run a merged beat can report.
    localparam logic [3:0] RUN_MAX = 4'd15;

endpackage

// File: rtl/step_decode.sv
// Turns two consecutive locations back into the move code that links them.
// adj_o is low unless exactly one nibble moved by exactly one, without wrap.
module step_decode
    import maze_pkg::*;
(
    input  logic [7:0] prev_i,
    input  logic [7:0] cur_i,
    output dir_t       dir_o,
    output logic       adj_o
);

    // One extra bit keeps F+1 from aliasing onto 0.
    logic [4:0] px, py, cx, cy;

    assign px = {1'b0, prev_i[7:4]};
    assign py = {1'b0, prev_i[3:0]};
    assign cx = {1'b0, cur_i[7:4]};
    assign cy = {1'b0, cur_i[3:0]};

    always_comb begin
        dir_o = DIR_YDEC;
        adj_o = 1'b0;
        if (py == cy) begin
            if (cx == px + 5'd1) begin
                dir_o = DIR_XINC;
                adj_o = 1'b1;
            end else if (px == cx + 5'd1) begin
                dir_o = DIR_XDEC;
                adj_o = 1'b1;
            end
        end else if (px == cx) begin
            if (cy == py + 5'd1) begin
                dir_o = DIR_YINC;
                adj_o = 1'b1;
            end else if (py == cy + 5'd1) begin
                dir_o = DIR_YDEC;
                adj_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/path_reader.sv
// Mirrors the solver's location stack and replays it as move codes over valid/ready.
// Optional macro PATH_READER_RUNLEN_EN merges equal consecutive moves into {dirOut, dirRun} beats.
module path_reader
    import maze_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    locIn,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic          start,
    input  logic          dirReady,
    output logic [1:0]    dirOut,
    output logic          dirValid,
    output logic          done,
    output logic          err,
    output logic          ovf,
    output logic          busy,
    output logic [AW:0]   depth
`ifdef PATH_READER_RUNLEN_EN
    ,
    output logic [3:0]    dirRun
`endif
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] TWO  = (AW+1)'(2);

    rd_state_t     state_q, state_d;
    loc_t          mem_q [DEPTH];
    logic [AW:0]   depth_q, depth_d, depth_m1;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_addr;
    loc_t          prev_q, prev_d, cur;
    logic          err_q, err_d, ovf_q, ovf_d;
    logic          wr_en, at_last, step_adj;
    dir_t          step_dir;
`ifdef PATH_READER_RUNLEN_EN
    logic [3:0]    run_q, run_d;
    dir_t          rdir_q, rdir_d;
    logic          beat_q, beat_d, last_q, last_d;
`endif

    assign depth_m1 = depth_q - ONE;
    assign cur      = mem_q[rd_ptr_q];
    assign at_last  = ({1'b0, rd_ptr_q} == depth_m1);

    step_decode u_step (
        .prev_i (prev_q),
        .cur_i  (cur),
        .dir_o  (step_dir),
        .adj_o  (step_adj)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (!clear && start) state_d = (depth_q >= TWO) ? EMIT : DONE;
`ifdef PATH_READER_RUNLEN_EN
            EMIT: begin
                if (beat_q) begin
                    if (dirReady && last_q) state_d = DONE;
                end else if (!step_adj) begin
                    state_d = DONE;
                end
            end
`else
            EMIT: if (!step_adj || (dirReady && at_last)) state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        depth_d  = depth_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        wr_addr  = depth_q[AW-1:0];
        prev_d   = prev_q;
        rd_ptr_d = rd_ptr_q;
`ifdef PATH_READER_RUNLEN_EN
        run_d    = run_q;
        rdir_d   = rdir_q;
        beat_d   = beat_q;
        last_d   = last_q;
`endif
        if (state_q == IDLE) begin
            if (clear) begin
                depth_d = '0;
                err_d   = 1'b0;
                ovf_d   = 1'b0;
            end else begin
                // push+pop on a non-empty stack rewrites the top in place
                if (push && pop && depth_q != '0) begin
                    wr_en   = 1'b1;
                    wr_addr = depth_m1[AW-1:0];
                end else if (push) begin
                    if (depth_q == FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        depth_d = depth_q + ONE;
                    end
                end else if (pop && depth_q != '0) begin
                    depth_d = depth_m1;
                end
                if (start) begin
                    prev_d   = mem_q[0];
                    rd_ptr_d = AW'(1);
`ifdef PATH_READER_RUNLEN_EN
                    run_d    = '0;
                    beat_d   = 1'b0;
                    last_d   = 1'b0;
`endif
                end
            end
        end else begin
            if (push || pop) err_d = 1'b1;
            if (state_q == EMIT) begin
`ifdef PATH_READER_RUNLEN_EN
                if (beat_q) begin
                    if (dirReady) begin
                        run_d  = '0;
                        beat_d = 1'b0;
                    end
                end else if (!step_adj) begin
                    err_d = 1'b1;
                end else if (run_q != '0 && step_dir != rdir_q) begin
                    // Closing a run costs a cycle; the differing step is re-decoded afterwards.
                    beat_d = 1'b1;
                    last_d = 1'b0;
                end else begin
                    prev_d   = cur;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    rdir_d   = step_dir;
                    run_d    = run_q + 4'd1;
                    if (at_last || run_q == RUN_MAX - 4'd1) begin
                        beat_d = 1'b1;
                        last_d = at_last;
                    end
                end
`else
                if (!step_adj) begin
                    err_d = 1'b1;
                end else if (dirReady) begin
                    prev_d   = cur;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth_q  <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= '0;
`ifdef PATH_READER_RUNLEN_EN
            run_q    <= '0;
            beat_q   <= 1'b0;
            last_q   <= 1'b0;
`endif
        end else begin
            depth_q  <= depth_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            rd_ptr_q <= rd_ptr_d;
`ifdef PATH_READER_RUNLEN_EN
            run_q    <= run_d;
            beat_q   <= beat_d;
            last_q   <= last_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        prev_q <= prev_d;
`ifdef PATH_READER_RUNLEN_EN
        rdir_q <= rdir_d;
`endif
        if (wr_en) mem_q[wr_addr] <= locIn;
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
`ifdef PATH_READER_RUNLEN_EN
        dirValid = (state_q == EMIT) && beat_q;
        dirOut   = dirValid ? rdir_q : DIR_YDEC;
        dirRun   = dirValid ? run_q : 4'd0;
`else
        dirValid = (state_q == EMIT) && step_adj;
        dirOut   = dirValid ? step_dir : DIR_YDEC;
`endif
    end

    assign err   = err_q;
    assign ovf   = ovf_q;
    assign depth = depth_q;

endmodule

// File: tb/tb_path_reader.sv
// Bench for path_reader: table-driven recording, hand-written replay corner cases,
// and randomized paths checked against a queue-based model of the path and its moves.
module tb_path_reader;
    import maze_pkg::*;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    locIn;
    logic          push, pop, clear, start, dirReady;
    logic [1:0]    dirOut;
    logic          dirValid, done, err, ovf, busy;
    logic [AW:0]   depth;
`ifdef PATH_READER_RUNLEN_EN
    logic [3:0]    dirRun;
`endif

    path_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .locIn    (locIn),
        .push     (push),
        .pop      (pop),
        .clear    (clear),
        .start    (start),
        .dirReady (dirReady),
        .dirOut   (dirOut),
        .dirValid (dirValid),
        .done     (done),
        .err      (err),
        .ovf      (ovf),
        .busy     (busy),
        .depth    (depth)
`ifdef PATH_READER_RUNLEN_EN
        ,
        .dirRun   (dirRun)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] path_q [$];
    bit         m_ovf = 0;
    bit         m_err = 0;
    int         last_got [$];

    typedef struct {
        int         op;       // 0 push, 1 pop, 2 push+pop, 3 clear
        logic [7:0] loc;
        int         exp_depth;
        bit         exp_ovf;
    } rec_t;

    rec_t tbl [7];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int enc(input int d, input int r);
`ifdef PATH_READER_RUNLEN_EN
        return d * 16 + r;
`else
        if (r == 0) return -1;
        return d;
`endif
    endfunction

    function automatic int beat_now();
`ifdef PATH_READER_RUNLEN_EN
        return int'(dirOut) * 16 + int'(dirRun);
`else
        return int'(dirOut);
`endif
    endfunction

    // Moves from coordinate differences; beats are those moves (merged into runs when enabled).
    function automatic void model_replay(output int beats [$], output bit bad);
        int moves [$];
        logic [7:0] a, b;
        int dx, dy, cd, cnt;
        beats = {};
        bad = 0;
        for (int i = 1; i < path_q.size(); i++) begin
            a = path_q[i-1];
            b = path_q[i];
            dx = int'(b[7:4]) - int'(a[7:4]);
            dy = int'(b[3:0]) - int'(a[3:0]);
            if (dx == 0 && dy == -1)      moves.push_back(0);
            else if (dx == 1 && dy == 0)  moves.push_back(1);
            else if (dx == -1 && dy == 0) moves.push_back(2);
            else if (dx == 0 && dy == 1)  moves.push_back(3);
            else begin
                bad = 1;
                break;
            end
        end
`ifdef PATH_READER_RUNLEN_EN
        cd = 0;
        cnt = 0;
        foreach (moves[i]) begin
            if (cnt > 0 && moves[i] != cd) begin
                beats.push_back(enc(cd, cnt));
                cnt = 0;
            end
            cd = moves[i];
            cnt++;
            if (cnt == 15) begin
                beats.push_back(enc(cd, cnt));
                cnt = 0;
            end
        end
        if (cnt > 0 && !bad) beats.push_back(enc(cd, cnt));
`else
        cd = 0;
        cnt = 0;
        foreach (moves[i]) beats.push_back(enc(moves[i], 1));
`endif
    endfunction

    task automatic check_rec(input string nm);
        check({nm, "_depth"}, int'(depth), path_q.size());
        check({nm, "_ovf"}, int'(ovf), int'(m_ovf));
        check({nm, "_err"}, int'(err), int'(m_err));
    endtask

    task automatic do_op(input int op, input logic [7:0] l);
        locIn = l;
        push  = (op == 0 || op == 2);
        pop   = (op == 1 || op == 2);
        clear = (op == 3);
        @(posedge clk); #1;
        push = 0; pop = 0; clear = 0;
        case (op)
            0: if (path_q.size() < DEPTH) path_q.push_back(l); else m_ovf = 1;
            1: if (path_q.size() > 0) void'(path_q.pop_back());
            2: if (path_q.size() > 0) path_q[path_q.size()-1] = l; else path_q.push_back(l);
            default: begin path_q.delete(); m_ovf = 0; m_err = 0; end
        endcase
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low 3 cycles at the second beat
    task automatic replay(input int mode, input string tag);
        int exp_b [$];
        bit bad, pending, seen, rdy;
        int cyc, stalled, first_acc, done_cyc, pend_beat, cb;
        model_replay(exp_b, bad);
        last_got = {};
        start = 1; dirReady = 0;
        @(posedge clk); #1;
        start = 0;
        cyc = 1; pending = 0; stalled = 0; seen = 0; first_acc = -1; done_cyc = -1; pend_beat = 0;
        while (cyc < 600) begin
            if (done) begin
                seen = 1;
                done_cyc = cyc;
                break;
            end
            if (dirValid) begin
                cb = beat_now();
                if (pending) check({tag, "_hold"}, cb, pend_beat);
                rdy = 1;
                if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
                if (mode == 2 && last_got.size() == 1 && stalled < 3) begin
                    rdy = 0;
                    stalled++;
                end
                dirReady = rdy;
                if (rdy) begin
                    last_got.push_back(cb);
                    if (first_acc < 0) first_acc = cyc;
                    pending = 0;
                end else begin
                    pending = 1;
                    pend_beat = cb;
                end
            end else begin
                if (pending) check({tag, "_valid_dropped"}, 0, 1);
                pending = 0;
                dirReady = ($urandom_range(0, 1) != 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        dirReady = 0;
        check({tag, "_done_seen"}, int'(seen), 1);
        m_err = m_err | bad;
        check({tag, "_beats"}, last_got.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < last_got.size(); i++)
            check({tag, "_beat"}, last_got[i], exp_b[i]);
        check({tag, "_err"}, int'(err), int'(m_err));
        check({tag, "_depth"}, int'(depth), path_q.size());
`ifndef PATH_READER_RUNLEN_EN
        if (mode == 0) begin
            check({tag, "_done_cyc"}, done_cyc, exp_b.size() + (bad ? 2 : 1));
            if (exp_b.size() > 0) check({tag, "_first_cyc"}, first_acc, 1);
        end
`endif
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_idle"}, int'(busy), 0);
    endtask

    function automatic logic [7:0] next_loc(input logic [7:0] p, input int pref);
        int x, y, d, nx, ny;
        x = int'(p[7:4]);
        y = int'(p[3:0]);
        if ($urandom_range(0, 29) == 0) return 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            d = ($urandom_range(0, 9) < 7) ? pref : int'($urandom_range(0, 3));
            nx = x + ((d == 1) ? 1 : 0) - ((d == 2) ? 1 : 0);
            ny = y + ((d == 3) ? 1 : 0) - ((d == 0) ? 1 : 0);
            if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16) return {4'(nx), 4'(ny)};
        end
        return {4'(x), (y < 15) ? 4'(y + 1) : 4'(y - 1)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, pref;
        logic [7:0] l;
        bit seen;
        rst = 0; locIn = 0; push = 0; pop = 0; clear = 0; start = 0; dirReady = 0;
        #1;
        check("rst_dirValid", int'(dirValid), 0);
        check("rst_dirOut", int'(dirOut), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_depth", int'(depth), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;

        // Basic path and back-pressure
        do_op(3, 0);
        do_op(0, 8'h00); do_op(0, 8'h01); do_op(0, 8'h11); do_op(0, 8'h12);
        check_rec("rec4");
        replay(0, "basic");
        check("basic_b0", last_got.size() > 0 ? last_got[0] : -1, enc(3, 1));
        check("basic_b1", last_got.size() > 1 ? last_got[1] : -1, enc(1, 1));
        check("basic_b2", last_got.size() > 2 ? last_got[2] : -1, enc(3, 1));
        check("basic_depth4", int'(depth), 4);
        replay(2, "stall");
        check("stall_b1", last_got.size() > 1 ? last_got[1] : -1, enc(1, 1));

        // Recording table
        tbl[0] = '{0, 8'h00, 1, 0};
        tbl[1] = '{0, 8'h01, 2, 0};
        tbl[2] = '{0, 8'h02, 3, 0};
        tbl[3] = '{1, 8'h00, 2, 0};
        tbl[4] = '{0, 8'h11, 3, 0};
        tbl[5] = '{2, 8'h22, 3, 0};
        tbl[6] = '{1, 8'h00, 2, 0};
        do_op(3, 0);
        for (int i = 0; i < 5; i++) begin
            do_op(tbl[i].op, tbl[i].loc);
            check("tbl_depth", int'(depth), tbl[i].exp_depth);
            check("tbl_ovf", int'(ovf), int'(tbl[i].exp_ovf));
        end
        replay(0, "popped");
        check("popped_b0", last_got.size() > 0 ? last_got[0] : -1, enc(3, 1));
        check("popped_b1", last_got.size() > 1 ? last_got[1] : -1, enc(1, 1));
        do_op(tbl[5].op, tbl[5].loc);
        check("pp_depth", int'(depth), tbl[5].exp_depth);
        replay(0, "pp");
        check("pp_err", int'(err), 1);
        do_op(tbl[6].op, tbl[6].loc);
        check("tbl6_depth", int'(depth), tbl[6].exp_depth);

        // Wrap is non-adjacent
        do_op(3, 0);
        do_op(0, 8'h0F); do_op(0, 8'h00);
        replay(0, "wrap");
        check("wrap_nobeat", last_got.size(), 0);
        check("wrap_err", int'(err), 1);
        do_op(3, 0);
        check("clr_err", int'(err), 0);
        check("clr_depth", int'(depth), 0);

        // Overflow, then replace at full
        for (int i = 0; i <= DEPTH; i++) do_op(0, 8'(i));
        check("ovf_flag", int'(ovf), 1);
        check("ovf_depth", int'(depth), DEPTH);
        do_op(2, 8'h77);
        check_rec("full_pp");

        // Single entry: done, no move
        do_op(3, 0);
        do_op(0, 8'h55);
        replay(0, "one");
        check("one_nobeat", last_got.size(), 0);

        // push and clear while busy
        do_op(3, 0);
        do_op(0, 8'h00); do_op(0, 8'h01); do_op(0, 8'h02);
        start = 1;
        @(posedge clk); #1;
        start = 0; push = 1; locIn = 8'h33;
        @(posedge clk); #1;
        push = 0; clear = 1;
        m_err = 1;
        check("busy_push_err", int'(err), 1);
        check("busy_push_depth", int'(depth), 3);
        @(posedge clk); #1;
        clear = 0;
        check("busy_clear_depth", int'(depth), 3);
        check("busy_clear_err", int'(err), 1);
        dirReady = 1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1;
            else begin @(posedge clk); #1; end
        end
        dirReady = 0;
        check("busy_done_seen", int'(seen), 1);
        @(posedge clk); #1;

`ifdef PATH_READER_RUNLEN_EN
        do_op(3, 0);
        do_op(0, 8'h00); do_op(0, 8'h01); do_op(0, 8'h02); do_op(0, 8'h03); do_op(0, 8'h13);
        replay(0, "run");
        check("run_b0", last_got.size() > 0 ? last_got[0] : -1, enc(3, 3));
        check("run_b1", last_got.size() > 1 ? last_got[1] : -1, enc(1, 1));
        do_op(3, 0);
        for (int i = 0; i < 16; i++) do_op(0, {4'(i), 4'h0});
        do_op(0, 8'hF1);
        replay(0, "cap");
        check("cap_b0", last_got.size() > 0 ? last_got[0] : -1, enc(1, 15));
        check("cap_b1", last_got.size() > 1 ? last_got[1] : -1, enc(3, 1));
`endif

        // Randomized paths
        for (int it = 0; it < 30; it++) begin
            do_op(3, 0);
            n = int'($urandom_range(2, 24));
            pref = int'($urandom_range(0, 3));
            l = 8'($urandom);
            do_op(0, l);
            for (int k = 1; k < n; k++) begin
                l = next_loc(path_q[path_q.size()-1], pref);
                case ($urandom_range(0, 9))
                    0: do_op(1, 0);
                    1: do_op(2, l);
                    default: do_op(0, l);
                endcase
            end
            check_rec("rnd_rec");
            replay(1, "rnd");
        end

        // Asynchronous reset mid replay
        do_op(3, 0);
        do_op(0, 8'h00); do_op(0, 8'h01); do_op(0, 8'h02); do_op(0, 8'h03);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check("ar_valid_before", int'(dirValid), 1);
        #2 rst = 0;
        #1;
        check("ar_valid", int'(dirValid), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_depth", int'(depth), 0);
        rst = 1;
        path_q.delete(); m_err = 0; m_ovf = 0;
        @(posedge clk); #1;
        check_rec("ar_after");
        check("ar_busy_after", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/path_reader.md
Name: path_reader

Overview:
- Trails the maze-solver stack: it mirrors every location push and pop the solver makes into its own buffer.
- On `start`, it replays the recorded path from the first entry to the last. Each pair of consecutive locations is decoded back into a 2-bit move code, the inverse of the solver's direction-to-location step.
- Move codes are offered to a downstream consumer (motion driver or display) over a valid/ready handshake.

Parameters:
- DEPTH, 64, number of location entries the buffer holds.
- AW, 6, pointer/count width; DEPTH == 2**AW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- locIn  in  8  location being pushed, {x[3:0], y[3:0]}.
- push  in  1  append locIn to the top of the buffer.
- pop  in  1  remove the top entry.
- clear  in  1  synchronous empty of the buffer; also clears err and ovf.
- start  in  1  begin replay; sampled only in IDLE.
- dirReady  in  1  consumer accepts dirOut this cycle.
- dirOut  out  2  move code: 00 y-1, 01 x+1, 10 x-1, 11 y+1.
- dirValid  out  1  dirOut holds a valid move.
- done  out  1  one-cycle pulse when a replay ends.
- err  out  1  sticky flag: non-adjacent pair found, or push/pop issued while busy.
- ovf  out  1  sticky flag: push attempted while full.
- busy  out  1  high in every state except IDLE.
- depth  out  AW+1  current number of entries, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; depth=0; state IDLE; buffer contents don't-care.
- IDLE, recording:
  - push with depth<DEPTH: write mem[depth]=locIn, depth+1.
  - push with depth==DEPTH: ignored, ovf<=1.
  - pop with depth>0: depth-1. pop with depth==0: ignored, no flag.
  - push and pop in the same cycle: the top entry is replaced by locIn, depth unchanged. If depth==0, treat as a plain push.
  - clear has priority over push/pop and start.
- IDLE + start:
  - depth>=2: go to EMIT with prev=mem[0], rdPtr=1.
  - depth<2: go to DONE; no move is emitted.
- EMIT:
  - dirValid=1; dirOut=decode(prev, mem[rdPtr]).
  - Adjacent means exactly one nibble differs, and by exactly +/-1. There is no modulo-16 wrap: F->0 is non-adjacent.
  - dirOut and dirValid hold stable until dirReady is high.
  - On dirValid&dirReady: prev<=mem[rdPtr], rdPtr+1. If the accepted beat was rdPtr==depth-1, go to DONE.
  - Non-adjacent pair: dirValid stays 0, err<=1, go to DONE next cycle.
- Latency: the first dirValid appears in the cycle after start is sampled. With dirReady held high, one move is emitted per cycle; N entries give N-1 moves.
- DONE: done=1 for exactly one cycle, then IDLE. Buffer contents are retained, so a replay can be repeated.
- push/pop while busy: ignored, err<=1.
- clear while busy: ignored.
- rst mid-replay: immediate return to IDLE, depth=0, dirValid drops asynchronously.

Optional Feature:
- Macro: PATH_READER_RUNLEN_EN.
  - Adds output dirRun[3:0].
  - In EMIT, consecutive equal moves are merged internally before being offered. A beat ends when the next move differs, the run reaches 15, or the path ends.
  - The beat presents {dirOut, dirRun}, with dirRun in 1..15.
  - Presenting a merged beat may take up to run+1 cycles after the previous acceptance.
  - err detection is unchanged and aborts any partial run without emitting it.
- Without the macro: no dirRun port; one move per beat, as specified above.

Decomposition:
- Package maze_pkg:
  - loc_t (8-bit {x,y}).
  - dir_t (2-bit) with DIR_YDEC=00, DIR_XINC=01, DIR_XDEC=10, DIR_YINC=11.
  - rd_state_t enum {IDLE, EMIT, DONE}.
- Sub-module step_decode (combinational): inputs prev and cur loc_t; outputs dir_t and adj.
- Buffer array, pointers and FSM stay in path_reader.

Test Plan:
- Push 00,01,11,12, then start, dirReady=1 -> dirOut 11,01,11 on consecutive cycles, done pulses the cycle after the third move, depth stays 4.
- Same path with dirReady low for 3 cycles at the second beat -> dirOut=01 held stable with dirValid=1 throughout; no beat skipped or duplicated.
- Push 00,01,02, then pop, then push 11 -> buffer holds 00,01,11; replay gives 11,01. Separately, a same-cycle push+pop with locIn=22 at depth 3 -> top entry becomes 22, depth stays 3.
- Push 0F,00 (wrap), then start -> dirValid never asserts, err=1, done pulses; clear -> err=0, depth=0.
- DEPTH+1 pushes -> ovf=1, depth=DEPTH. Separately, start with depth=1 -> done pulse next cycle, no dirValid.
- With PATH_READER_RUNLEN_EN: path 00,01,02,03,13 -> beats {11,3} then {01,1}. rst asserted mid-replay -> dirValid=0 immediately, busy=0, depth=0.
